// File: rtl/input_sram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : input_sram_pkg
// Brief   : Shared types and constants for the input-activation SRAM arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package input_sram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int BANK_SEL_LSB     = 11;
    localparam int BANK_SEL_MSB     = 13;

    localparam int DEF_NUM_READERS  = 4;
    localparam int DEF_ADDR_W       = 32;
    localparam int DEF_DATA_W       = 64;

endpackage
`default_nettype wire

// File: rtl/input_sram_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Brief   : Combinational round-robin pick: first request at or after i_ptr.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]    o_gnt_id
);

    int w_idx;

    // Scan farthest offset first so the closest request to the pointer wins.
    always_comb begin
        o_gnt    = '0;
        o_gnt_id = '0;
        w_idx    = 0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            w_idx = (int'(i_ptr) + off) % NUM_REQ;
            if (i_req[w_idx]) begin
                o_gnt        = '0;
                o_gnt[w_idx] = 1'b1;
                o_gnt_id     = ID_W'(w_idx);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/input_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : input_sram_arbiter
// Brief   : Shares the input SRAM controller between one loader and N readers.
// Revision: 1.0 - initial release
// ============================================================================
module input_sram_arbiter
    import input_sram_pkg::*;
#(
    parameter int NUM_READERS  = DEF_NUM_READERS,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int NUM_BANKS    = 6,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 15
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          wr_req,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          wr_ack,
    output logic                          wr_err,
    input  logic [NUM_READERS-1:0]        rd_req,
    input  logic [NUM_READERS*ADDR_W-1:0] rd_addr,
    output logic [NUM_READERS-1:0]        rd_valid,
    output logic                          rd_err,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          busy,
    output logic                          sram_w_en,
    output logic                          sram_r_en,
    output logic [ADDR_W-1:0]             sram_w_addr,
    output logic [DATA_W-1:0]             sram_w_d,
    output logic [ADDR_W-1:0]             sram_r_addr,
    input  logic [DATA_W-1:0]             sram_r_d,
    input  logic                          sram_d_ready,
    input  logic                          sram_w_done
);

    localparam int ID_W     = $clog2(NUM_READERS);
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam int TMO_W    = $clog2(TIMEOUT + 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [ID_W-1:0]        r_ptr;
    logic [NUM_READERS-1:0] r_gnt;
    logic [STARVE_W-1:0]    r_starve;
    logic [TMO_W-1:0]       r_tmo;
    logic                   r_is_rd;
    logic                   r_err;
    logic [DATA_W-1:0]      r_cap_data;

    logic                   w_any_req;
    logic                   w_any_rd;
    logic                   w_rd_wins;
    logic                   w_bad_bank;
    logic                   w_done;
    logic                   w_tmo_hit;
    logic [NUM_READERS-1:0] w_rd_gnt;
    logic [ID_W-1:0]        w_rd_id;
    logic [ADDR_W-1:0]      w_sel_addr;

    rr_arbiter #(
        .NUM_REQ (NUM_READERS),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .i_req    (rd_req),
        .i_ptr    (r_ptr),
        .o_gnt    (w_rd_gnt),
        .o_gnt_id (w_rd_id)
    );

    assign w_any_rd   = |rd_req;
    assign w_any_req  = wr_req | w_any_rd;
    assign w_rd_wins  = w_any_rd && (!wr_req || (r_starve == STARVE_W'(STARVE_LIMIT)));
    assign w_sel_addr = w_rd_wins ? rd_addr[int'(w_rd_id)*ADDR_W +: ADDR_W] : wr_addr;
    assign w_bad_bank = int'(w_sel_addr[BANK_SEL_MSB:BANK_SEL_LSB]) >= NUM_BANKS;
    assign w_done     = r_is_rd ? sram_d_ready : sram_w_done;
    assign w_tmo_hit  = (r_tmo == TMO_W'(TIMEOUT));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any_req) w_state_nxt = w_bad_bank ? RESP : WAIT;
            WAIT:    if (w_done || w_tmo_hit) w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ptr       <= '0;
            r_gnt       <= '0;
            r_starve    <= '0;
            r_tmo       <= '0;
            r_is_rd     <= 1'b0;
            r_err       <= 1'b0;
            r_cap_data  <= '0;
            wr_ack      <= 1'b0;
            wr_err      <= 1'b0;
            rd_valid    <= '0;
            rd_err      <= 1'b0;
            rd_data     <= '0;
            busy        <= 1'b0;
            sram_w_en   <= 1'b0;
            sram_r_en   <= 1'b0;
            sram_w_addr <= '0;
            sram_w_d    <= '0;
            sram_r_addr <= '0;
        end else begin
            sram_w_en <= 1'b0;
            sram_r_en <= 1'b0;
            wr_ack    <= 1'b0;
            wr_err    <= 1'b0;
            rd_valid  <= '0;
            rd_err    <= 1'b0;
            busy      <= (w_state_nxt != IDLE);
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_is_rd    <= w_rd_wins;
                        r_err      <= w_bad_bank;
                        r_tmo      <= '0;
                        r_cap_data <= '0;
                        if (w_rd_wins) begin
                            r_gnt    <= w_rd_gnt;
                            r_ptr    <= (w_rd_id == ID_W'(NUM_READERS - 1)) ? '0 : w_rd_id + 1'b1;
                            r_starve <= '0;
                        end else if (!w_any_rd) begin
                            r_starve <= '0;
                        end else if (r_starve != STARVE_W'(STARVE_LIMIT)) begin
                            r_starve <= r_starve + 1'b1;
                        end
                        if (!w_bad_bank) begin
                            if (w_rd_wins) begin
                                sram_r_en   <= 1'b1;
                                sram_r_addr <= w_sel_addr;
                            end else begin
                                sram_w_en   <= 1'b1;
                                sram_w_addr <= w_sel_addr;
                                sram_w_d    <= wr_data;
                            end
                        end
                    end
                end
                WAIT: begin
                    if (w_done) begin
                        if (r_is_rd) r_cap_data <= sram_r_d;
                    end else if (w_tmo_hit) begin
                        r_err      <= 1'b1;
                        r_cap_data <= '0;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                RESP: begin
                    if (r_is_rd) begin
                        rd_valid <= r_gnt;
                        rd_err   <= r_err;
                        rd_data  <= r_cap_data;
                    end else begin
                        wr_ack <= 1'b1;
                        wr_err <= r_err;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_input_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_input_sram_arbiter
// Brief   : Directed self-checking bench for input_sram_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_input_sram_arbiter;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 64;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           wr_req = 1'b0;
    logic [AW-1:0]  wr_addr = '0;
    logic [DW-1:0]  wr_data = '0;
    logic           wr_ack, wr_err;
    logic [NR-1:0]  rd_req = '0;
    logic [NR*AW-1:0] rd_addr = '0;
    logic [NR-1:0]  rd_valid;
    logic           rd_err;
    logic [DW-1:0]  rd_data;
    logic           busy;
    logic           sram_w_en, sram_r_en;
    logic [AW-1:0]  sram_w_addr, sram_r_addr;
    logic [DW-1:0]  sram_w_d;
    logic [DW-1:0]  sram_r_d;
    logic           sram_d_ready, sram_w_done;

    // Controller model: answers one cycle after the strobe when enabled.
    logic           mdl_en = 1'b1;
    logic           use_fixed = 1'b0;
    logic [DW-1:0]  fixed_rdata = '0;
    logic           mdl_ready = 1'b0;
    logic           mdl_wdone = 1'b0;
    logic [DW-1:0]  mdl_rdata = '0;
    logic           man_ready = 1'b0;
    logic           man_wdone = 1'b0;

    int             n_assert = 0;
    int             n_fail = 0;
    int             ev_cnt;
    logic [4:0]     ev [0:5];

    always #5 clock = ~clock;

    always @(posedge clock) begin
        mdl_ready <= mdl_en && sram_r_en;
        mdl_wdone <= mdl_en && sram_w_en;
        if (sram_r_en) mdl_rdata <= use_fixed ? fixed_rdata : {32'hA5A5_0000, sram_r_addr};
    end

    assign sram_d_ready = mdl_ready | man_ready;
    assign sram_w_done  = mdl_wdone | man_wdone;
    assign sram_r_d     = mdl_rdata;

    input_sram_arbiter dut (
        .clock        (clock),
        .reset        (reset),
        .wr_req       (wr_req),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_ack       (wr_ack),
        .wr_err       (wr_err),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_valid     (rd_valid),
        .rd_err       (rd_err),
        .rd_data      (rd_data),
        .busy         (busy),
        .sram_w_en    (sram_w_en),
        .sram_r_en    (sram_r_en),
        .sram_w_addr  (sram_w_addr),
        .sram_w_d     (sram_w_d),
        .sram_r_addr  (sram_r_addr),
        .sram_r_d     (sram_r_d),
        .sram_d_ready (sram_d_ready),
        .sram_w_done  (sram_w_done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        // Reset
        tick(3);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_strobes", 64'({sram_w_en, sram_r_en}), 64'd0);
        check("rst_acks", 64'({wr_ack, wr_err, rd_valid, rd_err}), 64'd0);
        check("rst_rd_data", rd_data, 64'd0);
        reset = 1'b0;
        tick();

        // Single read from reader 2, bank 1
        use_fixed   = 1'b1;
        fixed_rdata = 64'hDEAD_BEEF_0000_0001;
        rd_addr[2*AW +: AW] = 32'h0000_0810;
        rd_req = 4'b0100;
        tick();
        check("rd1_r_en", 64'(sram_r_en), 64'd1);
        check("rd1_r_addr", 64'(sram_r_addr), 64'h810);
        check("rd1_busy", 64'(busy), 64'd1);
        tick();
        check("rd1_r_en_pulse", 64'(sram_r_en), 64'd0);
        tick();
        check("rd1_early_valid", 64'(rd_valid), 64'd0);
        tick();
        check("rd1_valid", 64'(rd_valid), 64'b0100);
        check("rd1_data", rd_data, 64'hDEAD_BEEF_0000_0001);
        check("rd1_err", 64'(rd_err), 64'd0);
        rd_req = '0;
        tick();
        check("rd1_valid_clr", 64'(rd_valid), 64'd0);
        check("rd1_data_hold", rd_data, 64'hDEAD_BEEF_0000_0001);
        check("rd1_idle", 64'(busy), 64'd0);
        use_fixed = 1'b0;

        // Single write to bank 5 (last valid bank)
        wr_addr = 32'h0000_2F08;
        wr_data = 64'h1122_3344_5566_7788;
        wr_req  = 1'b1;
        tick();
        check("wr1_w_en", 64'(sram_w_en), 64'd1);
        check("wr1_w_addr", 64'(sram_w_addr), 64'h2F08);
        check("wr1_w_d", sram_w_d, 64'h1122_3344_5566_7788);
        tick(2);
        check("wr1_early_ack", 64'(wr_ack), 64'd0);
        tick();
        check("wr1_ack", 64'({wr_ack, wr_err}), 64'b10);
        wr_req = 1'b0;
        tick();
        check("wr1_ack_clr", 64'(wr_ack), 64'd0);

        // Write priority and starvation: expect W W W W R W
        for (int i = 0; i < 6; i++) ev[i] = '0;
        ev_cnt  = 0;
        wr_addr = 32'h0000_0100;
        rd_addr[0 +: AW] = 32'h0000_0000;
        wr_req  = 1'b1;
        rd_req  = 4'b0001;
        for (int cyc = 0; cyc < 80 && ev_cnt < 6; cyc++) begin
            tick();
            if (wr_ack) begin
                ev[ev_cnt] = 5'h10;
                ev_cnt++;
            end else if (|rd_valid) begin
                ev[ev_cnt] = {1'b0, rd_valid};
                ev_cnt++;
                rd_req = '0;
            end
            if (ev_cnt == 6) wr_req = 1'b0;
        end
        wr_req = 1'b0;
        rd_req = '0;
        check("starve_ev_cnt", 64'(ev_cnt), 64'd6);
        for (int i = 0; i < 6; i++)
            check($sformatf("starve_ev%0d", i), 64'(ev[i]), (i == 4) ? 64'h01 : 64'h10);
        tick(2);

        // Bad bank write: bank 6
        wr_addr = 32'h0000_3000;
        wr_req  = 1'b1;
        tick();
        check("bad_no_w_en", 64'(sram_w_en), 64'd0);
        check("bad_busy", 64'(busy), 64'd1);
        tick();
        check("bad_ack_err", 64'({wr_ack, wr_err}), 64'b11);
        check("bad_no_w_en2", 64'(sram_w_en), 64'd0);
        wr_req = 1'b0;
        tick();
        check("bad_ack_clr", 64'({wr_ack, wr_err}), 64'b00);

        // Timeout on a read; stray write-done must be ignored
        mdl_en = 1'b0;
        rd_addr[1*AW +: AW] = 32'h0000_0008;
        rd_req = 4'b0010;
        tick(3);
        man_wdone = 1'b1;
        tick();
        man_wdone = 1'b0;
        tick(13);
        check("tmo_not_yet", 64'(rd_valid), 64'd0);
        tick();
        check("tmo_valid", 64'(rd_valid), 64'b0010);
        check("tmo_err", 64'(rd_err), 64'd1);
        check("tmo_data", rd_data, 64'd0);
        rd_req = '0;
        tick();
        check("tmo_err_clr", 64'(rd_err), 64'd0);
        mdl_en = 1'b1;
        rd_req = 4'b0010;
        tick(4);
        check("post_tmo_valid", 64'(rd_valid), 64'b0010);
        check("post_tmo_err", 64'(rd_err), 64'd0);
        check("post_tmo_data", rd_data, 64'hA5A5_0000_0000_0008);
        rd_req = '0;
        tick(2);

        // Reset in WAIT; late d_ready ignored
        mdl_en = 1'b0;
        rd_req = 4'b0010;
        tick();
        check("mid_r_en", 64'(sram_r_en), 64'd1);
        reset  = 1'b1;
        rd_req = '0;
        tick();
        check("mid_rst_outs", 64'({busy, sram_r_en, sram_w_en, rd_valid, rd_err, wr_ack}), 64'd0);
        check("mid_rst_addr", 64'(sram_r_addr), 64'd0);
        reset     = 1'b0;
        man_ready = 1'b1;
        tick();
        man_ready = 1'b0;
        tick();
        check("late_ready_ign", 64'({busy, rd_valid}), 64'd0);
        tick();
        check("late_ready_ign2", 64'({busy, rd_valid}), 64'd0);
        mdl_en = 1'b1;

        // Round robin from pointer 0: 0,1,2,3,0
        for (int i = 0; i < NR; i++) rd_addr[i*AW +: AW] = 32'(32'h40 * (i + 1));
        for (int i = 0; i < 6; i++) ev[i] = '0;
        ev_cnt = 0;
        rd_req = 4'b1111;
        for (int cyc = 0; cyc < 60 && ev_cnt < 5; cyc++) begin
            tick();
            if (|rd_valid) begin
                ev[ev_cnt] = {1'b0, rd_valid};
                check($sformatf("rr_data%0d", ev_cnt), rd_data,
                      {32'hA5A5_0000, 32'(32'h40 * ((ev_cnt % NR) + 1))});
                ev_cnt++;
            end
            if (ev_cnt == 5) rd_req = '0;
        end
        rd_req = '0;
        check("rr_ev_cnt", 64'(ev_cnt), 64'd5);
        check("rr_ev0", 64'(ev[0]), 64'b0001);
        check("rr_ev1", 64'(ev[1]), 64'b0010);
        check("rr_ev2", 64'(ev[2]), 64'b0100);
        check("rr_ev3", 64'(ev[3]), 64'b1000);
        check("rr_ev4", 64'(ev[4]), 64'b0001);
        tick(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/input_sram_arbiter.md
Name: input_sram_arbiter

Overview:
- Shares the input-activation SRAM controller between one loader write port (DMA/fill) and NUM_READERS PE read ports.
- Accepts level requests and issues single-cycle w_en/r_en pulses to the controller.
- Waits for w_done/d_ready, then returns a one-cycle ack or read data to the granted requester.
- Rejects out-of-range bank addresses, and recovers via timeout if the controller never responds.

Parameters:
- NUM_READERS, 4, number of PE read ports (2..8)
- ADDR_W, 32, address width
- DATA_W, 64, data width
- NUM_BANKS, 6, valid bank rows; bank index = addr[13:11]
- STARVE_LIMIT, 4, consecutive write grants allowed while any reader waits
- TIMEOUT, 15, WAIT cycles before error return

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wr_req  in  1  loader write request (level)
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_ack  out  1  one-cycle write complete
- wr_err  out  1  one-cycle write error (bad bank or timeout); coincident with wr_ack
- rd_req  in  NUM_READERS  per-reader request (level)
- rd_addr  in  NUM_READERS*ADDR_W  packed read addresses; reader i at [i*ADDR_W +: ADDR_W]
- rd_valid  out  NUM_READERS  one-hot, one-cycle read response
- rd_err  out  1  error flag, valid with rd_valid
- rd_data  out  DATA_W  read data, valid with rd_valid
- busy  out  1  high when not IDLE
- sram_w_en  out  1  write strobe to controller
- sram_r_en  out  1  read strobe to controller
- sram_w_addr  out  ADDR_W  write address to controller
- sram_w_d  out  DATA_W  write data to controller
- sram_r_addr  out  ADDR_W  read address to controller
- sram_r_d  in  DATA_W  controller read data
- sram_d_ready  in  1  controller read done
- sram_w_done  in  1  controller write done

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE; round-robin pointer 0; starve and timeout counters 0.
  - An in-flight transaction is dropped with no ack; strobes are low from the cycle after the reset edge.
- All outputs are registered.
- Requesters hold req/addr/data stable until their ack. If req is still high in the cycle after ack, it is a new request.
- FSM states:
  - IDLE
    - No req: stay.
    - Else choose a winner:
      - Write wins, unless starve_cnt == STARVE_LIMIT and some rd_req is high; then a reader wins.
      - Reader pick: round-robin, first set rd_req at or after the pointer, wrapping.
    - Bank check: if the winner's addr[13:11] >= NUM_BANKS, go to RESP with error and issue no strobe.
    - Otherwise latch addr/data/id into the sram_* registers, pulse the strobe, and go to WAIT.
  - WAIT
    - Strobe is 0. The done input matching the op type (sram_w_done or sram_d_ready) moves to RESP, capturing sram_r_d on reads.
    - The non-matching done input is ignored.
    - tmo_cnt increments each cycle. When tmo_cnt == TIMEOUT, go to RESP with error and rd_data = 0.
  - RESP
    - Pulse wr_ack (+wr_err) or rd_valid[id] (+rd_err, rd_data) for exactly one cycle, then go to IDLE.
    - rd_data holds its value after RESP; rd_err and wr_err clear.
- Read latency, with request sampled at edge E0 in IDLE:
  - sram_r_en high in cycle E0..E1.
  - Controller d_ready after E2.
  - rd_valid high in cycle E3..E4.
  - Request-to-response is 4 cycles minimum; the same applies to writes.
- Throughput: one transaction per 4 cycles minimum; never more than one outstanding.
- Pointer update: after a read grant, pointer = granted id + 1, wrapping to 0 at NUM_READERS. Unchanged on write grants.
- Starvation counter:
  - Increments on a write grant while any rd_req is high.
  - Saturates at STARVE_LIMIT.
  - Clears on any read grant, and on a write grant with no readers waiting.
- Error-path grants (bad bank) still update the pointer and starve counter.
- Simultaneous wr_req and all rd_req with counter below the limit: the write wins.

Decomposition:
- Package input_sram_pkg holds:
  - State enum {IDLE, WAIT, RESP}.
  - BANK_SEL_LSB=11, BANK_SEL_MSB=13.
  - Default widths.
- One sub-module: rr_arbiter (NUM_READERS req vector + pointer -> one-hot grant + id, purely combinational).

Test Plan:
- Single read: rd_req[2]=1, addr 0x0000_0810, controller model returns 0xDEAD_BEEF_0000_0001 → sram_r_en for 1 cycle; rd_valid=4'b0100 four cycles after sampling; rd_data matches; rd_err=0.
- Write priority + starvation, STARVE_LIMIT=4: wr_req held high, rd_req[0] high → 4 write grants, then 1 read grant, then writes resume.
- Round-robin: rd_req=4'b1111 held, no writes → grant order 0,1,2,3,0.
- Bad bank: wr_req with addr 0x0000_3000 (bank 6) → no sram_w_en; wr_ack=1 with wr_err=1 in RESP, 2 cycles after sampling.
- Timeout: read issued and controller model never asserts d_ready → rd_valid with rd_err=1 and rd_data=0 after 15 WAIT cycles; next request is served normally.
- Reset mid-WAIT: assert reset in WAIT → all outputs 0 next cycle; the late sram_d_ready is ignored; pointer is 0 afterwards.
